// File: rtl/buf_rx_demux.sv
// buf_rx_demux: receive-side demultiplexer for decoded 64b/66b blocks.
// Start blocks classify a message (REQ/MEM/NET). Its data blocks are then written
// into the matching receive queue, and a per-class finish pulse is raised at
// terminate. A message is refused at start when its queue lacks space, and is
// aborted mid-flight on overflow or on a protocol error.
module buf_rx_demux #(
    parameter int         DATA_W     = 64,
    parameter int         MIN_SPACE  = 5,
    parameter int         MAX_WORDS  = 8,
    parameter logic [7:0] START_CODE = 8'h78,
    parameter logic [7:0] TERM_CODE  = 8'hFD
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_valid,
    input  logic [1:0]        rx_sync,
    input  logic [DATA_W-1:0] rx_data,
    input  logic [3:0]        memq_space,
    input  logic [3:0]        netq_space,
    input  logic [3:0]        reqq_space,
    output logic              memq_write,
    output logic              netq_write,
    output logic              reqq_write,
    output logic [DATA_W-1:0] wdata,
    output logic              memfin,
    output logic              netfin,
    output logic              reqfin,
    output logic              abort,
    output logic [1:0]        abort_cls,
    output logic [15:0]       drop_cnt
);

    localparam logic [1:0]       CLS_NONE = 2'd0;
    localparam int               CNT_W    = $clog2(MAX_WORDS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_WORDS);
    localparam logic [3:0]       MIN_SP   = 4'(MIN_SPACE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [1:0]        r_cls;
    logic [1:0]        w_cls_next;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_next;

    // Output registers; one-hot index 0 = REQ, 1 = MEM, 2 = NET
    logic [2:0]        r_wr;
    logic [2:0]        r_fin;
    logic [DATA_W-1:0] r_wdata;
    logic              r_abort;
    logic [1:0]        r_abort_cls;
    logic [15:0]       r_drop_cnt;

    logic [1:0]        w_wr_cls;
    logic [1:0]        w_fin_cls;
    logic [2:0]        w_wr_oh;
    logic [2:0]        w_fin_oh;
    logic [DATA_W-1:0] w_wdata_next;
    logic              w_abort_next;
    logic [1:0]        w_abort_cls_next;
    logic [1:0]        w_drop_inc;
    logic [16:0]       w_drop_sum;
    logic [15:0]       w_drop_next;

    // Block decode
    logic              w_is_data;
    logic              w_is_start;
    logic              w_is_term;
    logic [1:0]        w_new_cls;
    logic [3:0]        w_space [4];
    logic [3:0]        w_space_new;
    logic [3:0]        w_space_cur;
    logic              w_start_ok;

    assign w_is_data   = (rx_sync == 2'b10);
    assign w_is_start  = (rx_sync == 2'b01) && (rx_data[7:0] == START_CODE);
    assign w_is_term   = (rx_sync == 2'b01) && (rx_data[7:0] == TERM_CODE);
    assign w_new_cls   = rx_data[9:8];

    // Space table indexed by class code; class 00 never has room
    assign w_space[0]  = 4'd0;
    assign w_space[1]  = reqq_space;
    assign w_space[2]  = memq_space;
    assign w_space[3]  = netq_space;
    assign w_space_new = w_space[w_new_cls];
    assign w_space_cur = w_space[r_cls];
    assign w_start_ok  = (w_new_cls != CLS_NONE) && (w_space_new >= MIN_SP);

    // Next-state and next-output logic; idle cycles leave everything untouched
    always_comb begin
        w_state_next     = r_state;
        w_cls_next       = r_cls;
        w_count_next     = r_count;
        w_wr_cls         = CLS_NONE;
        w_fin_cls        = CLS_NONE;
        w_wdata_next     = r_wdata;
        w_abort_next     = 1'b0;
        w_abort_cls_next = r_abort_cls;
        w_drop_inc       = 2'd0;
        if (rx_valid) begin
            case (r_state)
                ST_RECV: begin
                    if (w_is_data) begin
                        if ((r_count < MAX_CNT) && (w_space_cur != 4'd0)) begin
                            w_wr_cls     = r_cls;
                            w_wdata_next = rx_data;
                            w_count_next = r_count + CNT_W'(1);
                        end else begin
                            w_abort_next     = 1'b1;
                            w_abort_cls_next = r_cls;
                            w_drop_inc       = 2'd1;
                            w_state_next     = ST_DROP;
                        end
                    end else if (w_is_term) begin
                        if (r_count != '0) begin
                            w_fin_cls = r_cls;
                        end else begin
                            // Empty message: reported as an abort
                            w_abort_next     = 1'b1;
                            w_abort_cls_next = r_cls;
                            w_drop_inc       = 2'd1;
                        end
                        w_state_next = ST_IDLE;
                    end else if (w_is_start) begin
                        // Abort the open message and evaluate the new start now
                        w_abort_next     = 1'b1;
                        w_abort_cls_next = r_cls;
                        if (w_start_ok) begin
                            w_drop_inc   = 2'd1;
                            w_state_next = ST_RECV;
                            w_cls_next   = w_new_cls;
                            w_count_next = '0;
                        end else begin
                            w_drop_inc   = 2'd2;
                            w_state_next = ST_DROP;
                        end
                    end else begin
                        // Invalid sync header or unexpected control block
                        w_abort_next     = 1'b1;
                        w_abort_cls_next = r_cls;
                        w_drop_inc       = 2'd1;
                        w_state_next     = ST_DROP;
                    end
                end
                default: begin
                    // IDLE and DROP: only start and terminate blocks matter
                    if (w_is_start) begin
                        if (w_start_ok) begin
                            w_state_next = ST_RECV;
                            w_cls_next   = w_new_cls;
                            w_count_next = '0;
                        end else begin
                            w_drop_inc   = 2'd1;
                            w_state_next = ST_DROP;
                        end
                    end else if (w_is_term) begin
                        w_state_next = ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Class code to one-hot strobe decode
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cls_dec
            assign w_wr_oh[gi]  = (w_wr_cls == 2'(gi + 1));
            assign w_fin_oh[gi] = (w_fin_cls == 2'(gi + 1));
        end
    endgenerate

    // Saturating drop counter increment (0, 1 or 2 per block)
    assign w_drop_sum  = {1'b0, r_drop_cnt} + {15'd0, w_drop_inc};
    assign w_drop_next = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];

    // Message tracking state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cls   <= CLS_NONE;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_cls   <= w_cls_next;
            r_count <= w_count_next;
        end
    end

    // Registered outputs: strobes and pulses appear one cycle after their block
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr        <= 3'd0;
            r_fin       <= 3'd0;
            r_wdata     <= '0;
            r_abort     <= 1'b0;
            r_abort_cls <= 2'd0;
            r_drop_cnt  <= 16'd0;
        end else begin
            r_wr        <= w_wr_oh;
            r_fin       <= w_fin_oh;
            r_wdata     <= w_wdata_next;
            r_abort     <= w_abort_next;
            r_abort_cls <= w_abort_cls_next;
            r_drop_cnt  <= w_drop_next;
        end
    end

    assign reqq_write = r_wr[0];
    assign memq_write = r_wr[1];
    assign netq_write = r_wr[2];
    assign reqfin     = r_fin[0];
    assign memfin     = r_fin[1];
    assign netfin     = r_fin[2];
    assign wdata      = r_wdata;
    assign abort      = r_abort;
    assign abort_cls  = r_abort_cls;
    assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_buf_rx_demux.sv
// Testbench for buf_rx_demux: directed scenarios plus a random block stream,
// all compared cycle by cycle against a message-level reference model.
`timescale 1ns/1ps
module tb_buf_rx_demux;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rx_valid;
    logic [1:0]  rx_sync;
    logic [63:0] rx_data;
    logic [3:0]  memq_space, netq_space, reqq_space;
    logic        memq_write, netq_write, reqq_write;
    logic [63:0] wdata;
    logic        memfin, netfin, reqfin, abort;
    logic [1:0]  abort_cls;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    buf_rx_demux dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_valid   (rx_valid),
        .rx_sync    (rx_sync),
        .rx_data    (rx_data),
        .memq_space (memq_space),
        .netq_space (netq_space),
        .reqq_space (reqq_space),
        .memq_write (memq_write),
        .netq_write (netq_write),
        .reqq_write (reqq_write),
        .wdata      (wdata),
        .memfin     (memfin),
        .netfin     (netfin),
        .reqfin     (reqfin),
        .abort      (abort),
        .abort_cls  (abort_cls),
        .drop_cnt   (drop_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: class codes 1=REQ 2=MEM 3=NET
    bit          m_in_msg;
    bit          m_discard;
    int          m_cls;
    int          m_words;
    int          m_drops;
    int          e_wr;
    int          e_fin;
    bit          e_abort;
    int          e_acls;
    logic [63:0] e_wdata;

    // Observed event tallies per scenario
    int cnt_wr [4];
    int cnt_fin[4];
    int cnt_abort;
    int last_acls;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h want=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int space_of(input int c);
        case (c)
            1: return int'(reqq_space);
            2: return int'(memq_space);
            3: return int'(netq_space);
            default: return 0;
        endcase
    endfunction

    function automatic logic [63:0] exp_drop();
        return (m_drops > 65535) ? 64'hFFFF : 64'(m_drops);
    endfunction

    task automatic model_reset();
        m_in_msg  = 0;
        m_discard = 0;
        m_cls     = 0;
        m_words   = 0;
        m_drops   = 0;
        e_wr      = 0;
        e_fin     = 0;
        e_abort   = 0;
        e_acls    = 0;
        e_wdata   = '0;
    endtask

    task automatic model_abort();
        e_abort  = 1;
        e_acls   = m_cls;
        m_drops++;
        m_in_msg = 0;
    endtask

    task automatic model_start(input int c);
        if (c == 0 || space_of(c) < 5) begin
            m_drops++;
            m_in_msg  = 0;
            m_discard = 1;
        end else begin
            m_in_msg  = 1;
            m_discard = 0;
            m_cls     = c;
            m_words   = 0;
        end
    endtask

    task automatic model_step(input logic v, input logic [1:0] s, input logic [63:0] d);
        bit is_start, is_term;
        e_wr    = 0;
        e_fin   = 0;
        e_abort = 0;
        if (!v) return;
        is_start = (s == 2'b01) && (d[7:0] == 8'h78);
        is_term  = (s == 2'b01) && (d[7:0] == 8'hFD);
        if (m_in_msg) begin
            if (s == 2'b10) begin
                if (m_words < 8 && space_of(m_cls) != 0) begin
                    e_wr    = m_cls;
                    e_wdata = d;
                    m_words++;
                end else begin
                    model_abort();
                    m_discard = 1;
                end
            end else if (is_term) begin
                if (m_words > 0) e_fin = m_cls;
                else model_abort();
                m_in_msg = 0;
            end else if (is_start) begin
                model_abort();
                model_start(int'(d[9:8]));
            end else begin
                model_abort();
                m_discard = 1;
            end
        end else if (is_start) begin
            model_start(int'(d[9:8]));
        end else if (is_term) begin
            m_discard = 0;
        end
    endtask

    task automatic compare_outputs();
        logic [6:0] got_st, exp_st;
        got_st = {memq_write, netq_write, reqq_write, memfin, netfin, reqfin, abort};
        exp_st = {e_wr == 2, e_wr == 3, e_wr == 1, e_fin == 2, e_fin == 3, e_fin == 1, e_abort};
        check_val("strobes", 64'(got_st), 64'(exp_st));
        if (e_wr != 0) check_val("wdata", wdata, e_wdata);
        if (e_abort) check_val("abort_cls", 64'(abort_cls), 64'(e_acls));
        check_val("drop_cnt", 64'(drop_cnt), exp_drop());
        if (reqq_write) cnt_wr[1]++;
        if (memq_write) cnt_wr[2]++;
        if (netq_write) cnt_wr[3]++;
        if (reqfin) cnt_fin[1]++;
        if (memfin) cnt_fin[2]++;
        if (netfin) cnt_fin[3]++;
        if (abort) begin
            cnt_abort++;
            last_acls = int'(abort_cls);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) begin
            cnt_wr[i]  = 0;
            cnt_fin[i] = 0;
        end
        cnt_abort = 0;
        last_acls = 0;
    endtask

    // One block per clock: drive at negedge, sample 1ns after the posedge
    task automatic step(input logic v, input logic [1:0] s, input logic [63:0] d);
        @(negedge clk);
        rx_valid = v;
        rx_sync  = s;
        rx_data  = d;
        model_step(v, s, d);
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    function automatic logic [63:0] mk_start(input logic [1:0] c);
        logic [63:0] d;
        d       = {$urandom, $urandom};
        d[9:8]  = c;
        d[7:0]  = 8'h78;
        return d;
    endfunction

    function automatic logic [63:0] mk_ctl(input logic [7:0] code);
        logic [63:0] d;
        d      = {$urandom, $urandom};
        d[7:0] = code;
        return d;
    endfunction

    task automatic send_start(input logic [1:0] c);
        step(1'b1, 2'b01, mk_start(c));
    endtask

    task automatic send_data();
        step(1'b1, 2'b10, {$urandom, $urandom});
    endtask

    task automatic send_term();
        step(1'b1, 2'b01, mk_ctl(8'hFD));
    endtask

    task automatic send_gap();
        step(1'b0, 2'($urandom_range(0, 3)), {$urandom, $urandom});
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once
    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check_val("rst_strobes", 64'({memq_write, netq_write, reqq_write, memfin, netfin, reqfin, abort}), 64'd0);
        check_val("rst_wdata", wdata, 64'd0);
        check_val("rst_abort_cls", 64'(abort_cls), 64'd0);
        check_val("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        rx_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b1;
        rx_valid   = 1'b0;
        rx_sync    = 2'b00;
        rx_data    = '0;
        memq_space = 4'd15;
        netq_space = 4'd15;
        reqq_space = 4'd15;
        model_reset();
        clear_counts();
        #2;
        do_reset();

        // Valid MEM message of three words
        clear_counts();
        memq_space = 4'd8;
        send_start(2'b10);
        repeat (3) send_data();
        send_term();
        send_gap();
        check_val("s1_mem_writes", 64'(cnt_wr[2]), 64'd3);
        check_val("s1_memfin", 64'(cnt_fin[2]), 64'd1);
        check_val("s1_other_writes", 64'(cnt_wr[1] + cnt_wr[3]), 64'd0);
        check_val("s1_drop", 64'(drop_cnt), 64'd0);
        $display("scenario valid_mem: writes=%0d fin=%0d", cnt_wr[2], cnt_fin[2]);

        // NET refused for space, then REQ accepted
        do_reset();
        clear_counts();
        netq_space = 4'd4;
        send_start(2'b11);
        repeat (2) send_data();
        send_term();
        check_val("s2_no_writes", 64'(cnt_wr[1] + cnt_wr[2] + cnt_wr[3]), 64'd0);
        check_val("s2_no_netfin", 64'(cnt_fin[3]), 64'd0);
        check_val("s2_drop", 64'(drop_cnt), 64'd1);
        reqq_space = 4'd15;
        send_start(2'b01);
        repeat (2) send_data();
        send_term();
        send_gap();
        check_val("s2_req_writes", 64'(cnt_wr[1]), 64'd2);
        check_val("s2_reqfin", 64'(cnt_fin[1]), 64'd1);
        $display("scenario space_refusal: drop=%0d req_writes=%0d", drop_cnt, cnt_wr[1]);

        // REQ length overflow
        do_reset();
        clear_counts();
        reqq_space = 4'd15;
        send_start(2'b01);
        repeat (9) send_data();
        send_term();
        send_gap();
        check_val("s3_req_writes", 64'(cnt_wr[1]), 64'd8);
        check_val("s3_abort", 64'(cnt_abort), 64'd1);
        check_val("s3_abort_cls", 64'(last_acls), 64'd1);
        check_val("s3_no_reqfin", 64'(cnt_fin[1]), 64'd0);
        check_val("s3_drop", 64'(drop_cnt), 64'd1);
        $display("scenario overflow: writes=%0d aborts=%0d", cnt_wr[1], cnt_abort);

        // Back-to-back start: MEM interrupted by NET
        do_reset();
        clear_counts();
        memq_space = 4'd8;
        netq_space = 4'd6;
        send_start(2'b10);
        repeat (2) send_data();
        send_start(2'b11);
        send_data();
        send_term();
        send_gap();
        check_val("s4_abort", 64'(cnt_abort), 64'd1);
        check_val("s4_abort_cls", 64'(last_acls), 64'd2);
        check_val("s4_net_writes", 64'(cnt_wr[3]), 64'd1);
        check_val("s4_netfin", 64'(cnt_fin[3]), 64'd1);
        check_val("s4_drop", 64'(drop_cnt), 64'd1);
        $display("scenario back_to_back: aborts=%0d net_writes=%0d", cnt_abort, cnt_wr[3]);

        // Gaps inside a message, then reset mid-message
        do_reset();
        clear_counts();
        memq_space = 4'd8;
        send_start(2'b10);
        send_gap();
        send_data();
        send_gap();
        send_gap();
        send_data();
        send_term();
        send_gap();
        check_val("s5_gap_writes", 64'(cnt_wr[2]), 64'd2);
        check_val("s5_gap_fin", 64'(cnt_fin[2]), 64'd1);
        netq_space = 4'd0;
        send_start(2'b11);
        send_start(2'b10);
        send_data();
        send_data();
        do_reset();
        clear_counts();
        repeat (3) send_data();
        check_val("s5_post_rst_writes", 64'(cnt_wr[1] + cnt_wr[2] + cnt_wr[3]), 64'd0);
        send_start(2'b10);
        send_data();
        send_term();
        send_gap();
        check_val("s5_post_rst_fin", 64'(cnt_fin[2]), 64'd1);
        $display("scenario gaps_reset: writes=%0d fin=%0d", cnt_wr[2], cnt_fin[2]);

        // Random block stream
        do_reset();
        clear_counts();
        for (int i = 0; i < 3000; i++) begin
            int r;
            if ($urandom_range(0, 7) == 0) begin
                memq_space = 4'($urandom_range(0, 15));
                netq_space = 4'($urandom_range(0, 15));
                reqq_space = 4'($urandom_range(0, 15));
            end
            r = $urandom_range(0, 99);
            if (r < 10) send_gap();
            else if (r < 22) send_start(2'($urandom_range(0, 3)));
            else if (r < 32) send_term();
            else if (r < 36) begin
                logic [7:0] code;
                code = 8'($urandom_range(0, 255));
                if (code == 8'h78 || code == 8'hFD) code = 8'h1E;
                step(1'b1, 2'b01, mk_ctl(code));
            end else if (r < 39) step(1'b1, ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00, {$urandom, $urandom});
            else send_data();
        end
        $display("scenario random: aborts=%0d drop=%0d", cnt_abort, drop_cnt);

        // Saturation of drop_cnt
        do_reset();
        clear_counts();
        netq_space = 4'd0;
        memq_space = 4'd8;
        repeat (65540) send_start(2'b11);
        check_val("s6_sat", 64'(drop_cnt), 64'hFFFF);
        send_start(2'b10);
        send_start(2'b11);
        check_val("s6_sat_hold", 64'(drop_cnt), 64'hFFFF);
        $display("scenario saturation: drop=0x%0h", drop_cnt);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
